// File: rtl/wide_add_sequencer_if.sv
// Handshake and operand/result bundle for wide_add_sequencer.
// The sub select only exists when WIDE_ADD_SUBTRACT_EN is defined.
interface wide_add_sequencer_if #(
    parameter int WORDS = 4
);
    logic                 start;
    logic [8*WORDS-1:0]   op_a;
    logic [8*WORDS-1:0]   op_b;
    logic                 cin;
`ifdef WIDE_ADD_SUBTRACT_EN
    logic                 sub;
`endif
    logic                 busy;
    logic                 done;
    logic [8*WORDS-1:0]   sum;
    logic                 cout;

`ifdef WIDE_ADD_SUBTRACT_EN
    modport master (output start, op_a, op_b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, op_a, op_b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, op_a, op_b, cin, input busy, done, sum, cout);
    modport slave  (input start, op_a, op_b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/wide_add_sequencer.sv
// (8*WORDS)-bit adder built by running one 8-bit ripple-carry lane adder once per byte, LSB first.
// Optional subtract mode is enabled by defining WIDE_ADD_SUBTRACT_EN.
module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wide_add_sequencer_if.slave  bus
);
    localparam int N  = 8 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic [IW-1:0]   idx;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic            carry_q;
    logic [N-1:0]    work_q;
    logic [N-1:0]    sum_q;
    logic            cout_q;
`ifdef WIDE_ADD_SUBTRACT_EN
    logic            sub_q;
`endif

    logic [7:0]      lane_a;
    logic [7:0]      lane_b;
    logic [7:0]      lane_sum;
    logic            lane_cout;
    logic [N-1:0]    work_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = RUN;
            RUN:     if (idx == LAST) next_state = DONE;
            DONE:    next_state = bus.start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

    // One byte lane of the shared 8-bit adder; work_next is the work register with this lane merged in.
    always_comb begin
        lane_a = a_q[{idx, 3'b000} +: 8];
        lane_b = b_q[{idx, 3'b000} +: 8];
`ifdef WIDE_ADD_SUBTRACT_EN
        if (sub_q) lane_b = ~lane_b;
`endif
        {lane_cout, lane_sum} = {1'b0, lane_a} + {1'b0, lane_b} + {8'b0, carry_q};
        work_next = work_q;
        work_next[{idx, 3'b000} +: 8] = lane_sum;
    end

    // Operands are captured only when a start is accepted; sum/cout update only on the last lane.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef WIDE_ADD_SUBTRACT_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_q <= bus.op_a;
                        b_q <= bus.op_b;
                        idx <= '0;
`ifdef WIDE_ADD_SUBTRACT_EN
                        sub_q   <= bus.sub;
                        carry_q <= bus.sub ? 1'b1 : bus.cin;
`else
                        carry_q <= bus.cin;
`endif
                    end
                end
                RUN: begin
                    work_q  <= work_next;
                    carry_q <= lane_cout;
                    if (idx == LAST) begin
                        sum_q  <= work_next;
                        cout_q <= lane_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: directed and random operations against a plain-arithmetic model.
// Define WIDE_ADD_SUBTRACT_EN to also exercise the subtract path.
module tb_wide_add_sequencer;
    localparam int WORDS = 4;
    localparam int N     = 8 * WORDS;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic [N-1:0] exp_sum;
    logic         exp_cout;
    logic [N-1:0] nxt_sum;
    logic         nxt_cout;

    wide_add_sequencer_if #(.WORDS(WORDS)) bus ();

    wide_add_sequencer #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives a request and predicts its result as a (N+1)-bit arithmetic sum.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input logic s);
        logic [N:0] full;
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.cin   = c;
`ifdef WIDE_ADD_SUBTRACT_EN
        bus.sub   = s;
`endif
        if (s) full = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
        else   full = {1'b0, a} + {1'b0, b} + (N+1)'(c);
        nxt_sum  = full[N-1:0];
        nxt_cout = full[N];
    endtask

    task automatic runOp(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input logic s,
                         input bit poke);
        applyStimulus(a, b, c, s);
        step();
        bus.start = 1'b0;
        for (int k = 0; k < WORDS; k++) begin
            checkOutput("busy_run", 64'(bus.busy), 64'd1);
            checkOutput("done_run", 64'(bus.done), 64'd0);
            checkOutput("sum_hold", 64'(bus.sum), 64'(exp_sum));
            checkOutput("cout_hold", 64'(bus.cout), 64'(exp_cout));
            bus.op_a  = N'($urandom);
            bus.op_b  = N'($urandom);
            bus.cin   = ~c;
            bus.start = (poke && k == 1);
            step();
        end
        bus.start = 1'b0;
        exp_sum  = nxt_sum;
        exp_cout = nxt_cout;
        checkOutput("done_pulse", 64'(bus.done), 64'd1);
        checkOutput("busy_done", 64'(bus.busy), 64'd0);
        checkOutput("sum", 64'(bus.sum), 64'(exp_sum));
        checkOutput("cout", 64'(bus.cout), 64'(exp_cout));
    endtask

    task automatic idleCycle();
        bus.start = 1'b0;
        step();
        checkOutput("busy_idle", 64'(bus.busy), 64'd0);
        checkOutput("done_idle", 64'(bus.done), 64'd0);
        checkOutput("sum_idle", 64'(bus.sum), 64'(exp_sum));
        checkOutput("cout_idle", 64'(bus.cout), 64'(exp_cout));
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.op_a  = N'($urandom);
        bus.op_b  = N'($urandom);
        bus.cin   = 1'b1;
`ifdef WIDE_ADD_SUBTRACT_EN
        bus.sub   = 1'b0;
`endif
        exp_sum  = '0;
        exp_cout = 1'b0;
        nxt_sum  = '0;
        nxt_cout = 1'b0;

        // Reset held with start asserted: nothing may start.
        repeat (2) begin
            step();
            checkOutput("rst_busy", 64'(bus.busy), 64'd0);
            checkOutput("rst_done", 64'(bus.done), 64'd0);
            checkOutput("rst_sum", 64'(bus.sum), 64'd0);
            checkOutput("rst_cout", 64'(bus.cout), 64'd0);
        end
        rst_n = 1'b1;
        idleCycle();

        runOp(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0);
        checkOutput("basic_sum_const", 64'(bus.sum), 64'h23456789);
        idleCycle();
        runOp(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0);
        idleCycle();
        runOp(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0);
        idleCycle();

        // Start pulsed mid-run is ignored and not queued; then back-to-back from DONE.
        runOp(N'($urandom), N'($urandom), 1'b1, 1'b0, 1'b1);
        runOp(32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
        checkOutput("b2b_sum_const", 64'(bus.sum), 64'd3);
        idleCycle();
        idleCycle();

        // Abort on the second RUN cycle.
        applyStimulus(N'($urandom), N'($urandom), 1'b0, 1'b0);
        step();
        bus.start = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        exp_sum  = '0;
        exp_cout = 1'b0;
        repeat (6) idleCycle();
        runOp(32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_sum_const", 64'(bus.sum), 64'd12);
        idleCycle();

        for (int i = 0; i < 10; i++) begin
            runOp(N'($urandom), N'($urandom), 1'($urandom), 1'b0, 1'($urandom));
            if (i % 3 == 0) idleCycle();
        end

`ifdef WIDE_ADD_SUBTRACT_EN
        idleCycle();
        runOp(32'd5, 32'd7, 1'b0, 1'b1, 1'b0);
        checkOutput("sub_neg_const", 64'(bus.sum), 64'hFFFFFFFE);
        checkOutput("sub_neg_cout", 64'(bus.cout), 64'd0);
        runOp(32'd7, 32'd5, 1'b0, 1'b1, 1'b0);
        checkOutput("sub_pos_const", 64'(bus.sum), 64'd2);
        checkOutput("sub_pos_cout", 64'(bus.cout), 64'd1);
        for (int i = 0; i < 6; i++) begin
            runOp(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
        idleCycle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Performs a (8*WORDS)-bit addition by time-multiplexing one instance of the team's 8-bit ripple-carry adder, one byte lane per clock, least-significant byte first.
- Owns operand capture, carry chaining between lanes, lane indexing and the start/busy/done handshake.
- Lets wide datapaths reuse the 8-bit adder instead of instantiating a full-width adder.

Parameters:
- WORDS, 4, number of 8-bit lanes; operand width = 8*WORDS; legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request; accepted only in IDLE or DONE.
- op_a  input  8*WORDS  operand A, sampled on accepting edge.
- op_b  input  8*WORDS  operand B, sampled on accepting edge.
- cin  input  1  carry into lane 0, sampled on accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  8*WORDS  result register.
- cout  output  1  carry out of the top lane.

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous, active-low (rst_n).
- Reset: state=IDLE, lane index=0, carry register=0, operand registers=0, busy=0, done=0, sum=0, cout=0.
- Reset applies on any edge with rst_n=0, including mid-RUN: the operation is aborted, no done is emitted, and partial results are discarded.
- States:
  - IDLE: start=1 -> capture op_a, op_b, cin into internal registers; idx=0; go to RUN.
  - RUN: adder inputs are A[8*idx+7:8*idx], B[8*idx+7:8*idx] and the carry register. On each edge, write the adder sum into work byte idx and load the adder carry-out into the carry register.
    - If idx==WORDS-1: copy the work register (including this lane) to sum, load the final carry into cout, go to DONE.
    - Otherwise: idx=idx+1.
  - DONE: done=1 for exactly this cycle.
    - start=1 -> capture new operands and go to RUN (back-to-back).
    - Otherwise go to IDLE.
- Latency: start accepted at edge E0; RUN occupies WORDS cycles; done is high in the cycle after edge E(WORDS). Throughput is one operation per WORDS+1 cycles.
- start while in RUN is ignored; the request is neither queued nor captured.
- busy=1 exactly in RUN; busy and done are never both high.
- sum and cout change only on RUN->DONE and otherwise hold their last result. They are not cleared when a new operation starts.
- Arithmetic is modulo 2^(8*WORDS); overflow is indicated only by cout.
- WORDS=1: RUN lasts one cycle; done follows 2 cycles after start acceptance.
- Operands changing after capture have no effect.

Optional Feature:
- Macro: WIDE_ADD_SUBTRACT_EN.
- With the macro defined:
  - Extra input port sub (1 bit), sampled with the operands.
  - sub=1: every B lane is inverted before the adder, and the lane-0 carry-in is forced to 1 (cin ignored), giving sum = A - B mod 2^(8*WORDS). cout=1 means no borrow (A>=B unsigned).
  - sub=0: behaviour is identical to the macro-undefined build.
- Without the macro: no sub port; addition only.

Test Plan (WORDS=4):
- Reset: hold rst_n=0 for 2 cycles with start=1 -> busy=0, done=0, sum=0, cout=0 throughout; no operation starts.
- Basic add: op_a=0x12345678, op_b=0x11111111, cin=0 -> busy high for 4 cycles; done pulses in the 5th cycle after acceptance; sum=0x23456789, cout=0.
- Full carry ripple across all lanes: op_a=0xFFFFFFFF, op_b=0x00000000, cin=1 -> sum=0x00000000, cout=1. Also op_a=op_b=0x80000000, cin=0 -> sum=0, cout=1.
- Handshake:
  - Pulse start mid-RUN with different operands -> ignored; the first result is unchanged.
  - Assert start during the DONE cycle with op_a=1, op_b=2 -> busy the next cycle, second done 5 cycles later with sum=3, while the first sum held until then.
- Abort: assert rst_n=0 on the 2nd RUN cycle -> no done; sum=0, cout=0; a subsequent start with 5+7 yields sum=12.
- WIDE_ADD_SUBTRACT_EN: sub=1 with op_a=0x00000005, op_b=0x00000007 -> sum=0xFFFFFFFE, cout=0. sub=1 with op_a=7, op_b=5 -> sum=2, cout=1.
